// File: rtl/soc_msp430_ram_arbiter.sv
// Two-master arbiter in front of a single-port 16-bit data RAM. The CPU data bus and a DMA
// master share the macro; one access is granted per cycle under a fixed, swappable priority.
// A starvation counter forces the low-priority master through after STARVE_MAX lost cycles.
module soc_msp430_ram_arbiter #(
  parameter int unsigned ADDR_MSB   = 6,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              mclk,
  input  logic              puc_rst,
  // CPU data bus
  input  logic              cpu_en,
  input  logic [ADDR_MSB:0] cpu_addr,
  input  logic [1:0]        cpu_wen,
  input  logic [15:0]       cpu_din,
  output logic              cpu_ack,
  output logic [15:0]       cpu_dout,
  output logic              cpu_dvalid,
  // DMA master
  input  logic              dma_en,
  input  logic [ADDR_MSB:0] dma_addr,
  input  logic [1:0]        dma_wen,
  input  logic [15:0]       dma_din,
  output logic              dma_ack,
  output logic [15:0]       dma_dout,
  output logic              dma_dvalid,
  input  logic              dma_prio,
  // RAM macro
  output logic [ADDR_MSB:0] ram_addr,
  output logic              ram_cen,
  output logic [1:0]        ram_wen,
  output logic [15:0]       ram_din,
  input  logic [15:0]       ram_dout
);

  localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

  typedef enum logic {OwnCpu, OwnDma} owner_e;

  logic [3:0] r_starve_cnt;
  logic [3:0] w_starve_cnt_nxt;
  logic       r_prio;
  logic       r_rd_pend;
  owner_e     r_owner;

  logic w_hi_en;
  logic w_lo_en;
  logic w_contend;
  logic w_force_lo;
  logic w_gnt_cpu;
  logic w_gnt_dma;
  logic w_lo_gnt;
  logic w_gnt_read;

  // dma_prio selects which master is "high"; the other one is guarded by the counter.
  assign w_hi_en    = dma_prio ? dma_en : cpu_en;
  assign w_lo_en    = dma_prio ? cpu_en : dma_en;
  assign w_contend  = w_hi_en & w_lo_en;
  assign w_force_lo = (r_starve_cnt == LP_STARVE_MAX);

  // Per-cycle grant decision; nothing is granted while reset is held.
  always_comb begin
    w_gnt_cpu = 1'b0;
    w_gnt_dma = 1'b0;
    if (!puc_rst) begin
      if (w_contend) begin
        // Low-priority master wins only when the starvation limit is reached.
        w_gnt_cpu = w_force_lo ? dma_prio : ~dma_prio;
        w_gnt_dma = w_force_lo ? ~dma_prio : dma_prio;
      end else begin
        w_gnt_cpu = cpu_en;
        w_gnt_dma = dma_en;
      end
    end
  end

  assign w_lo_gnt   = dma_prio ? w_gnt_cpu : w_gnt_dma;
  assign w_gnt_read = (w_gnt_cpu & (cpu_wen == 2'b11)) | (w_gnt_dma & (dma_wen == 2'b11));
  assign cpu_ack    = w_gnt_cpu;
  assign dma_ack    = w_gnt_dma;

  // Steer the granted master onto the RAM strobes; idle bus is parked at inactive values.
  always_comb begin
    ram_cen  = 1'b1;
    ram_wen  = 2'b11;
    ram_addr = '0;
    ram_din  = 16'h0000;
    if (w_gnt_cpu) begin
      ram_cen  = 1'b0;
      ram_wen  = cpu_wen;
      ram_addr = cpu_addr;
      ram_din  = cpu_din;
    end else if (w_gnt_dma) begin
      ram_cen  = 1'b0;
      ram_wen  = dma_wen;
      ram_addr = dma_addr;
      ram_din  = dma_din;
    end
  end

  // Starvation counter next state: counts cycles the low-priority master loses contention.
  always_comb begin
    w_starve_cnt_nxt = r_starve_cnt;
    if (w_lo_gnt || !w_lo_en || (dma_prio != r_prio)) begin
      w_starve_cnt_nxt = 4'd0;
    end else if (r_starve_cnt < LP_STARVE_MAX) begin
      // Low master requesting and not granted implies contention lost to the high master.
      w_starve_cnt_nxt = r_starve_cnt + 4'd1;
    end
  end

  // Arbitration state: starvation counter and registered priority select.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_starve_cnt <= 4'd0;
      r_prio       <= 1'b0;
    end else begin
      r_starve_cnt <= w_starve_cnt_nxt;
      r_prio       <= dma_prio;
    end
  end

  // Read tracking: remember who issued the read so the returning data is steered to it.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_rd_pend <= 1'b0;
      r_owner   <= OwnCpu;
    end else begin
      r_rd_pend <= w_gnt_read;
      if (w_gnt_read) begin
        r_owner <= w_gnt_dma ? OwnDma : OwnCpu;
      end
    end
  end

  assign cpu_dvalid = r_rd_pend & (r_owner == OwnCpu);
  assign dma_dvalid = r_rd_pend & (r_owner == OwnDma);
  assign cpu_dout   = cpu_dvalid ? ram_dout : 16'h0000;
  assign dma_dout   = dma_dvalid ? ram_dout : 16'h0000;

endmodule

// File: tb/tb_soc_msp430_ram_arbiter.sv
// Bench for soc_msp430_ram_arbiter: directed vector table, hand-written contention and
// reset-during-read sequences, then constrained-random traffic against a behavioural model.
module tb_soc_msp430_ram_arbiter;

  localparam int AM = 6;
  localparam int SM = 3;

  logic          mclk = 1'b0;
  logic          puc_rst;
  logic          cpu_en, dma_en, dma_prio;
  logic [AM:0]   cpu_addr, dma_addr, ram_addr;
  logic [1:0]    cpu_wen, dma_wen, ram_wen;
  logic [15:0]   cpu_din, dma_din, ram_din, ram_dout;
  logic [15:0]   cpu_dout, dma_dout;
  logic          cpu_ack, dma_ack, cpu_dvalid, dma_dvalid, ram_cen;

  soc_msp430_ram_arbiter #(.ADDR_MSB(AM), .STARVE_MAX(SM)) dut (
    .mclk(mclk), .puc_rst(puc_rst),
    .cpu_en(cpu_en), .cpu_addr(cpu_addr), .cpu_wen(cpu_wen), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_dout(cpu_dout), .cpu_dvalid(cpu_dvalid),
    .dma_en(dma_en), .dma_addr(dma_addr), .dma_wen(dma_wen), .dma_din(dma_din),
    .dma_ack(dma_ack), .dma_dout(dma_dout), .dma_dvalid(dma_dvalid),
    .dma_prio(dma_prio),
    .ram_addr(ram_addr), .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  always #5 mclk = ~mclk;

  // Behavioural single-port RAM: per-byte active-low writes, registered read data.
  logic [15:0] ram_mem [0:127];
  always @(posedge mclk) begin
    if (!ram_cen) begin
      if (!ram_wen[0]) ram_mem[ram_addr][7:0]  <= ram_din[7:0];
      if (!ram_wen[1]) ram_mem[ram_addr][15:8] <= ram_din[15:8];
      if (ram_wen == 2'b11) ram_dout <= ram_mem[ram_addr];
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_mem [0:127];
  int          m_wait;       // consecutive contention cycles lost by the low-priority master
  logic        m_prev_prio;
  logic        m_pend;
  int          m_owner;      // 1 = CPU, 2 = DMA
  logic [15:0] m_data;
  int          m_last_g;

  function automatic int exp_grant();
    int lo, hi;
    if (puc_rst) return 0;
    if (cpu_en && !dma_en) return 1;
    if (dma_en && !cpu_en) return 2;
    if (!cpu_en && !dma_en) return 0;
    lo = dma_prio ? 1 : 2;
    hi = dma_prio ? 2 : 1;
    return (m_wait >= SM) ? lo : hi;
  endfunction

  // Advance model and DUT by one rising edge, then step just past it.
  task automatic upd();
    int g;
    logic [AM:0] a;
    logic [1:0]  w;
    logic [15:0] d;
    @(posedge mclk);
    g = exp_grant();
    m_last_g = g;
    if (puc_rst) begin
      m_wait = 0; m_prev_prio = 1'b0; m_pend = 1'b0; m_owner = 1;
    end else begin
      if (cpu_en && dma_en && g == (dma_prio ? 2 : 1) && dma_prio == m_prev_prio) m_wait++;
      else m_wait = 0;
      m_prev_prio = dma_prio;
      m_pend = 1'b0;
      if (g != 0) begin
        a = (g == 1) ? cpu_addr : dma_addr;
        w = (g == 1) ? cpu_wen : dma_wen;
        d = (g == 1) ? cpu_din : dma_din;
        if (w == 2'b11) begin
          m_pend = 1'b1; m_owner = g; m_data = m_mem[a];
        end
        if (!w[0]) m_mem[a][7:0] = d[7:0];
        if (!w[1]) m_mem[a][15:8] = d[15:8];
      end
    end
    #1;
  endtask

  task automatic model_check();
    int g;
    g = exp_grant();
    chk("m_cpu_ack", cpu_ack, g == 1);
    chk("m_dma_ack", dma_ack, g == 2);
    chk("m_ram_cen", ram_cen, g == 0);
    chk("m_ram_addr", ram_addr, g == 1 ? cpu_addr : g == 2 ? dma_addr : '0);
    chk("m_ram_wen", ram_wen, g == 1 ? cpu_wen : g == 2 ? dma_wen : 2'b11);
    chk("m_ram_din", ram_din, g == 1 ? cpu_din : g == 2 ? dma_din : 16'h0);
    chk("m_cpu_dvalid", cpu_dvalid, m_pend && m_owner == 1);
    chk("m_dma_dvalid", dma_dvalid, m_pend && m_owner == 2);
    chk("m_cpu_dout", cpu_dout, (m_pend && m_owner == 1) ? m_data : 16'h0);
    chk("m_dma_dout", dma_dout, (m_pend && m_owner == 2) ? m_data : 16'h0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        rst;
    logic        c_en;  logic [AM:0] c_addr; logic [1:0] c_wen; logic [15:0] c_din;
    logic        d_en;  logic [AM:0] d_addr; logic [1:0] d_wen; logic [15:0] d_din;
    logic        prio;
    logic        e_cack, e_dack, e_cen, e_cdv, e_ddv;
    logic [15:0] e_cdout, e_ddout;
  } vec_t;

  function automatic vec_t mk(input logic rst,
      input logic ce, input int ca, input logic [1:0] cw, input logic [15:0] cd,
      input logic de, input int da, input logic [1:0] dw, input logic [15:0] dd,
      input logic ecack, input logic edack, input logic ecen,
      input logic ecdv, input logic [15:0] ecdo, input logic eddv, input logic [15:0] eddo);
    vec_t v;
    v.rst = rst; v.prio = 1'b0;
    v.c_en = ce; v.c_addr = (AM+1)'(ca); v.c_wen = cw; v.c_din = cd;
    v.d_en = de; v.d_addr = (AM+1)'(da); v.d_wen = dw; v.d_din = dd;
    v.e_cack = ecack; v.e_dack = edack; v.e_cen = ecen;
    v.e_cdv = ecdv; v.e_cdout = ecdo; v.e_ddv = eddv; v.e_ddout = eddo;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic ce, input int ca, input logic [1:0] cw,
      input logic [15:0] cd, input logic de, input int da, input logic [1:0] dw,
      input logic [15:0] dd, input logic pr);
    puc_rst = rst; dma_prio = pr;
    cpu_en = ce; cpu_addr = (AM+1)'(ca); cpu_wen = cw; cpu_din = cd;
    dma_en = de; dma_addr = (AM+1)'(da); dma_wen = dw; dma_din = dd;
  endtask

  vec_t vecs[11];

  initial begin
    logic exp_c;
    logic exp_d;
    logic prev_c;
    for (int i = 0; i < 128; i++) begin
      ram_mem[i] = 16'h0; m_mem[i] = 16'h0;
    end
    ram_dout = 16'h0;
    m_wait = 0; m_prev_prio = 1'b0; m_pend = 1'b0; m_owner = 1; m_data = 16'h0; m_last_g = 0;
    drive(1'b1, 1'b1, 0, 2'b11, 16'h0, 1'b1, 0, 2'b11, 16'h0, 1'b0);

    //             rst  cpu: en addr wen    din       dma: en addr wen    din
    //             cack dack cen  cdv cdout     ddv ddout
    vecs[0]  = mk(1, 1, 0, 2'b11, 16'h0,    1, 0, 2'b11, 16'h0,
                  0, 0, 1, 0, 16'h0, 0, 16'h0);
    vecs[1]  = mk(1, 1, 0, 2'b11, 16'h0,    1, 0, 2'b11, 16'h0,
                  0, 0, 1, 0, 16'h0, 0, 16'h0);
    vecs[2]  = mk(0, 1, 5, 2'b00, 16'h1234, 1, 3, 2'b11, 16'h0,
                  1, 0, 0, 0, 16'h0, 0, 16'h0);
    vecs[3]  = mk(0, 1, 5, 2'b11, 16'h0,    0, 0, 2'b11, 16'h0,
                  1, 0, 0, 0, 16'h0, 0, 16'h0);
    vecs[4]  = mk(0, 0, 0, 2'b11, 16'h0,    0, 0, 2'b11, 16'h0,
                  0, 0, 1, 1, 16'h1234, 0, 16'h0);
    vecs[5]  = mk(0, 0, 0, 2'b11, 16'h0,    1, 7, 2'b00, 16'h1234,
                  0, 1, 0, 0, 16'h0, 0, 16'h0);
    vecs[6]  = mk(0, 0, 0, 2'b11, 16'h0,    1, 7, 2'b01, 16'hAB00,
                  0, 1, 0, 0, 16'h0, 0, 16'h0);
    vecs[7]  = mk(0, 1, 7, 2'b11, 16'h0,    0, 0, 2'b11, 16'h0,
                  1, 0, 0, 0, 16'h0, 0, 16'h0);
    vecs[8]  = mk(0, 0, 0, 2'b11, 16'h0,    1, 7, 2'b11, 16'h0,
                  0, 1, 0, 1, 16'hAB34, 0, 16'h0);
    vecs[9]  = mk(0, 0, 0, 2'b11, 16'h0,    0, 0, 2'b11, 16'h0,
                  0, 0, 1, 0, 16'h0, 1, 16'hAB34);
    vecs[10] = mk(0, 0, 0, 2'b11, 16'h0,    0, 0, 2'b11, 16'h0,
                  0, 0, 1, 0, 16'h0, 0, 16'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].c_en, int'(vecs[i].c_addr), vecs[i].c_wen, vecs[i].c_din,
            vecs[i].d_en, int'(vecs[i].d_addr), vecs[i].d_wen, vecs[i].d_din, vecs[i].prio);
      @(negedge mclk);
      chk($sformatf("v%0d_cpu_ack", i), cpu_ack, vecs[i].e_cack);
      chk($sformatf("v%0d_dma_ack", i), dma_ack, vecs[i].e_dack);
      chk($sformatf("v%0d_ram_cen", i), ram_cen, vecs[i].e_cen);
      chk($sformatf("v%0d_cpu_dvalid", i), cpu_dvalid, vecs[i].e_cdv);
      chk($sformatf("v%0d_cpu_dout", i), cpu_dout, vecs[i].e_cdout);
      chk($sformatf("v%0d_dma_dvalid", i), dma_dvalid, vecs[i].e_ddv);
      chk($sformatf("v%0d_dma_dout", i), dma_dout, vecs[i].e_ddout);
      upd();
    end

    // Contention, CPU high priority: CPU,CPU,CPU,DMA repeating.
    prev_c = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1, 5, 2'b11, 16'h0, 1'b1, 7, 2'b11, 16'h0, 1'b0);
      @(negedge mclk);
      exp_c = (i % 4) != 3;
      chk($sformatf("p0_cpu_ack%0d", i), cpu_ack, exp_c);
      chk($sformatf("p0_dma_ack%0d", i), dma_ack, !exp_c);
      if (i > 0) chk($sformatf("p0_cpu_dvalid%0d", i), cpu_dvalid, prev_c);
      prev_c = exp_c;
      upd();
    end

    // Idle cycle while switching to DMA priority, then DMA,DMA,DMA,CPU,DMA,DMA.
    drive(1'b0, 1'b0, 0, 2'b11, 16'h0, 1'b0, 0, 2'b11, 16'h0, 1'b1);
    @(negedge mclk);
    upd();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 5, 2'b11, 16'h0, 1'b1, 7, 2'b11, 16'h0, 1'b1);
      @(negedge mclk);
      exp_d = (i % 4) != 3;
      chk($sformatf("p1_dma_ack%0d", i), dma_ack, exp_d);
      chk($sformatf("p1_cpu_ack%0d", i), cpu_ack, !exp_d);
      upd();
    end
    // Swap priority mid-burst with two losses counted: the swap clears the count,
    // so the DMA needs a full STARVE_MAX run before it is forced through.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 5, 2'b11, 16'h0, 1'b1, 7, 2'b11, 16'h0, 1'b0);
      @(negedge mclk);
      exp_c = (i != 4);
      chk($sformatf("sw_cpu_ack%0d", i), cpu_ack, exp_c);
      chk($sformatf("sw_dma_ack%0d", i), dma_ack, !exp_c);
      upd();
    end

    // Constrained-random traffic against the model; requests held until granted.
    for (int i = 0; i < 300; i++) begin
      if (!(cpu_en && m_last_g != 1) || $urandom_range(0, 99) < 8) begin
        cpu_en   = $urandom_range(0, 99) < 70;
        cpu_addr = (AM+1)'($urandom_range(0, 15));
        cpu_wen  = $urandom_range(0, 1) ? 2'b11 : 2'($urandom_range(0, 2));
        cpu_din  = 16'($urandom);
      end
      if (!(dma_en && m_last_g != 2) || $urandom_range(0, 99) < 8) begin
        dma_en   = $urandom_range(0, 99) < 70;
        dma_addr = (AM+1)'($urandom_range(0, 15));
        dma_wen  = $urandom_range(0, 1) ? 2'b11 : 2'($urandom_range(0, 2));
        dma_din  = 16'($urandom);
      end
      if ($urandom_range(0, 99) < 5) dma_prio = ~dma_prio;
      @(negedge mclk);
      model_check();
      upd();
    end

    // Reset asserted while a granted CPU read is returning its data.
    drive(1'b0, 1'b1, 20, 2'b00, 16'h5A5A, 1'b0, 0, 2'b11, 16'h0, 1'b0);
    @(negedge mclk);
    chk("rr_wr_ack", cpu_ack, 1'b1);
    upd();
    drive(1'b0, 1'b1, 20, 2'b11, 16'h0, 1'b0, 0, 2'b11, 16'h0, 1'b0);
    @(negedge mclk);
    chk("rr_rd_ack", cpu_ack, 1'b1);
    upd();
    drive(1'b0, 1'b1, 20, 2'b11, 16'h0, 1'b0, 0, 2'b11, 16'h0, 1'b0);
    #1;
    chk("rr_dvalid_pre", cpu_dvalid, 1'b1);
    chk("rr_dout_pre", cpu_dout, 16'h5A5A);
    puc_rst = 1'b1;
    #1;
    chk("rr_dvalid_rst", cpu_dvalid, 1'b0);
    chk("rr_dout_rst", cpu_dout, 16'h0);
    chk("rr_cen_rst", ram_cen, 1'b1);
    chk("rr_ack_rst", cpu_ack, 1'b0);
    upd();
    @(negedge mclk);
    chk("rr_cen_hold", ram_cen, 1'b1);
    chk("rr_dvalid_hold", cpu_dvalid, 1'b0);
    upd();
    puc_rst = 1'b0;
    @(negedge mclk);
    chk("rr_ack_after", cpu_ack, 1'b1);
    model_check();
    upd();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/soc_msp430_ram_arbiter.md
# soc_msp430_ram_arbiter

Two-port arbiter that shares one single-port data RAM (16-bit words, active-low chip enable, active-low per-byte write enables, read data valid the cycle after the access edge) between the CPU data bus and a DMA master. It sits between both masters and the RAM macro. Each cycle it grants at most one access, drives the RAM strobes and steers returned read data to the owning master with a valid flag. Fixed priority with a programmable swap and a starvation limiter guarantees the low-priority master bounded latency.

## Interface
Parameters:
- ADDR_MSB, 6: MSB of the word address bus.
- STARVE_MAX, 3: max consecutive denied contention cycles before the low-priority master is forced through; range 1..15.

Ports:
- mclk  in  1  clock; all state on rising edge.
- puc_rst  in  1  reset, asynchronous, active-high.
- cpu_en  in  1  CPU request, active-high.
- cpu_addr  in  ADDR_MSB+1  CPU word address.
- cpu_wen  in  2  CPU byte write enables, active-low; 2'b11 = read.
- cpu_din  in  16  CPU write data.
- cpu_ack  out  1  CPU access issued this cycle.
- cpu_dout  out  16  CPU read data.
- cpu_dvalid  out  1  cpu_dout valid this cycle.
- dma_en, dma_addr, dma_wen, dma_din, dma_ack, dma_dout, dma_dvalid: same as cpu_*, for DMA.
- dma_prio  in  1  0: CPU has priority; 1: DMA has priority.
- ram_addr  out  ADDR_MSB+1  RAM address.
- ram_cen  out  1  RAM chip enable, active-low.
- ram_wen  out  2  RAM byte write enables, active-low.
- ram_din  out  16  RAM write data.
- ram_dout  in  16  RAM read data, valid the cycle after the access edge.

## Operation
- Grant is combinational per cycle. Only one requester: it wins. Both: high-priority master wins unless starve_cnt == STARVE_MAX, in which case the low-priority master wins.
- Granted master: ram_cen=0; ram_addr/ram_wen/ram_din = its inputs; its ack=1. Other ack=0.
- No grant: ram_cen=1, ram_wen=2'b11, ram_addr=0, ram_din=0.
- While puc_rst=1: no grant, both acks 0.
- Requesters hold en/addr/wen/din stable until ack. Dropping en before ack is legal; no access occurs.
- starve_cnt, 4 bits: on each edge where both request and high-priority master wins, increment (saturate at STARVE_MAX). Clears on any edge where the low-priority master is granted, where the low-priority master is not requesting, or where dma_prio differs from its previous-cycle registered value.
- Read tracking: on each edge with a granted read (wen==2'b11), register owner and set rd_pend; otherwise clear rd_pend. Writes never produce dvalid.
- x_dvalid = rd_pend && owner==x. x_dout = ram_dout when x_dvalid, else 16'h0000.
- Partial writes (wen 01/10) pass through unchanged; byte merging is done by the RAM.

## Timing
- Reset values: starve_cnt=0, rd_pend=0, owner=CPU, dma_prio register=0. Therefore cpu_dvalid=dma_dvalid=0, both douts 0, both acks 0, ram_cen=1, ram_wen=2'b11, ram_addr=0, ram_din=0.
- Access: request and ack in cycle N. RAM samples at the end of N. For a read, dvalid and data appear in N+1.
- Throughput: one access per cycle total. A single master gets back-to-back grants every cycle.
- Worst-case low-priority wait under continuous contention: STARVE_MAX cycles.
- Consecutive reads by different masters: the dvalid pulses are in consecutive cycles, and each carries only its own data.
- Asserting reset mid-read clears rd_pend immediately (asynchronous). No dvalid is produced for the in-flight read.

## Test plan
- Reset: puc_rst=1 with both en=1. Required: acks 0, ram_cen=1, dvalid 0. After release, CPU is granted in the first cycle.
- CPU writes 0x1234 to addr 5 (wen 00), then reads addr 5. Required: cpu_ack in both cycles; cpu_dvalid=1 with cpu_dout=0x1234 in the cycle after the read; dma_dvalid stays 0.
- Contention, dma_prio=0, STARVE_MAX=3, both reading continuously. Required: grant pattern CPU,CPU,CPU,DMA repeating, and starve_cnt returns to 0 after each DMA grant.
- Same with dma_prio=1. Required: pattern DMA,DMA,DMA,CPU. Toggling dma_prio mid-burst clears the counter on the next edge.
- Addr 7 holds 0x1234. DMA writes wen=01, din=0xAB00, then CPU reads addr 7. Required: cpu_dout=0xAB34. A following DMA read produces dma_dvalid one cycle after cpu_dvalid, with no cross-steering.
- Granted CPU read in cycle N, puc_rst asserted during N+1. Required: cpu_dvalid drops at once, cpu_dout=0, and ram_cen=1 while reset is held.
